// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder slice used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one full-adder slice per clock.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one bit per edge through the slice
// DONE  | result held until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_a, bit_b, bit_sum, bit_cout, last_bit;

  assign bit_a    = a_reg[cnt[IW-1:0]];
  assign bit_b    = b_reg[cnt[IW-1:0]];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_adder u_slice (
    .a    (bit_a),
    .b    (bit_b),
    .cin  (carry),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  always_comb begin
    res_nxt = res_reg;
    res_nxt[cnt[IW-1:0]] = bit_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so the inversion happens once at accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_reg <= res_nxt;
          carry   <= bit_cout;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= bit_cout;
            ovf  <= carry ^ bit_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: 8-bit directed/random ops and an exhaustive 4-bit sweep.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [3:0] a4, b4, sum4;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  // Reference: true signed/unsigned arithmetic, reduced to w bits.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit c, input bit s,
                                output longint rs, output bit rc, output bit ro);
    longint md, half, sa, sb, r;
    md   = longint'(1) << w;
    half = md / 2;
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    if (s) begin
      r  = sa - sb - longint'(c);
      rc = (ua >= ub + longint'(c));
    end else begin
      r  = sa + sb + longint'(c);
      rc = (ua + ub + longint'(c) >= md);
    end
    ro = (r > half - 1) || (r < -half);
    rs = r & (md - 1);
  endfunction

  // Latency counts the accepting edge as edge 1.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input bit c, input bit s,
                        output logic [7:0] rs, output bit rc, output bit ro, output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = c; sub8 = s; in_valid8 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = sum8; rc = cout8; ro = ovf8;
  endtask

  task automatic release8();
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic do_op4(input logic [3:0] av, input logic [3:0] bv, input bit c, input bit s,
                        output logic [3:0] rs, output bit rc, output bit ro, output int lat);
    @(negedge clk);
    a4 = av; b4 = bv; cin4 = c; sub4 = s; in_valid4 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
    while (!out_valid4 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rs = sum4; rc = cout4; ro = ovf4;
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready8 got %b exp 1", in_ready8); end
    n_tests++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid8 got %b exp 0", out_valid8); end
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rst_busy8 got %b exp 0", busy8); end
    n_tests++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL rst_sum8 got %h exp 00", sum8); end
    n_tests++; if (cout8 !== 1'b0 || ovf8 !== 1'b0) begin n_fail++; $display("FAIL rst_flags8 got %b%b exp 00", cout8, ovf8); end
    n_tests++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctrl4 got %b%b%b exp 100", in_ready4, out_valid4, busy4); end
    n_tests++; if (sum4 !== 4'h0 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_result4 got %h %b %b exp 0 0 0", sum4, cout4, ovf4); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
    bit         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h80, 8'hFE, 8'h7F};
    bit         ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit         eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] rs; bit rc, ro; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op8(va[i], vb[i], 1'b0, vs[i], rs, rc, ro, lat);
      n_tests++; if (rs !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got %h exp %h", i, rs, es[i]); end
      n_tests++; if (rc !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", i, rc, ec[i]); end
      n_tests++; if (ro !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", i, ro, eo[i]); end
      n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp 9", i, lat); end
      release8();
    end
  endtask

  task automatic test_hold();
    longint es; bit ec, eo; int lat;
    model(8, 64'h3C, 64'h5A, 1'b0, 1'b0, es, ec, eo);
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
      n_fail++; $display("FAIL run_ctrl got busy=%b in_ready=%b exp 1 0", busy8, in_ready8); end
    // Keep offering different operands during RUN; they must be ignored.
    a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b1; sub8 = 1'b1;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL hold_latency got %0d exp 9", lat); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (sum8 !== es[7:0] || cout8 !== ec || ovf8 !== eo || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cyc%0d got sum=%h c=%b o=%b rdy=%b v=%b exp sum=%h c=%b o=%b rdy=0 v=1",
                 k, sum8, cout8, ovf8, in_ready8, out_valid8, es[7:0], ec, eo);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    n_tests++; if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || out_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL done_no_accept got rdy=%b busy=%b v=%b exp 1 0 0", in_ready8, busy8, out_valid8); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rs; bit rc, ro; int lat;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ctrl got v=%b busy=%b rdy=%b exp 0 0 1", out_valid8, busy8, in_ready8); end
    n_tests++; if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_result got %h %b %b exp 00 0 0", sum8, cout8, ovf8); end
    rst_n = 1'b1;
    do_op8(8'h12, 8'h34, 1'b0, 1'b0, rs, rc, ro, lat);
    n_tests++; if (rs !== 8'h46 || rc !== 1'b0 || ro !== 1'b0 || lat !== 9) begin
      n_fail++; $display("FAIL post_rst_op got %h %b %b lat=%0d exp 46 0 0 lat=9", rs, rc, ro, lat); end
    release8();
  endtask

  task automatic test_back_to_back();
    logic [7:0] av, bv, rs; bit c, s, rc, ro; int lat;
    longint es; bit ec, eo;
    for (int i = 0; i < 200; i++) begin
      av = 8'($urandom); bv = 8'($urandom); c = 1'($urandom); s = 1'($urandom);
      model(8, longint'(av), longint'(bv), c, s, es, ec, eo);
      do_op8(av, bv, c, s, rs, rc, ro, lat);
      n_tests++; if (rs !== es[7:0] || rc !== ec || ro !== eo || lat !== 9) begin
        n_fail++;
        $display("FAIL rand8 a=%h b=%h cin=%b sub=%b got %h %b %b lat=%0d exp %h %b %b lat=9",
                 av, bv, c, s, rs, rc, ro, lat, es[7:0], ec, eo);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        @(negedge clk);
      end
      release8();
    end
  endtask

  task automatic test_exhaustive4();
    logic [3:0] rs; bit rc, ro; int lat;
    longint es; bit ec, eo;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++) begin
            model(4, longint'(av), longint'(bv), 1'(c), 1'(s), es, ec, eo);
            do_op4(4'(av), 4'(bv), 1'(c), 1'(s), rs, rc, ro, lat);
            n_tests++; if (rs !== es[3:0] || rc !== ec || ro !== eo || lat !== 5) begin
              n_fail++;
              $display("FAIL sweep4 a=%h b=%h cin=%0d sub=%0d got %h %b %b lat=%0d exp %h %b %b lat=5",
                       av, bv, c, s, rs, rc, ro, lat, es[3:0], ec, eo);
            end
          end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high while in RUN.

Function
REQ-004 The block SHALL be a three-state FSM: IDLE, RUN and DONE.
REQ-005 In IDLE, in_ready SHALL be 1; on a clock edge with in_valid=1, the block SHALL do all of the following:
- latch a;
- latch b, inverted if sub=1;
- set the carry register to cin, or to ~cin if sub=1;
- clear the bit counter;
- go to RUN.
REQ-006 In RUN, each edge SHALL add bit[cnt] of the latched operands plus the carry register through a single 1-bit full-adder slice, LSB first.
- The sum bit goes to the result register at position cnt.
- The carry register is updated.
- The counter increments.
REQ-007 On the RUN edge where cnt = WIDTH-1, the block SHALL go to DONE and set the following:
- cout = final carry;
- ovf = carry into MSB XOR carry out of MSB.
REQ-008 out_valid SHALL assert exactly WIDTH+1 clock edges after the accepting edge (1 edge into RUN, WIDTH bit edges) and stay high only in DONE.
REQ-009 In DONE, sum, cout and ovf SHALL be held stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-010 in_ready SHALL be 0 in RUN and DONE: no overlap, and in_valid is ignored there.
REQ-011 Operand changes on a, b, cin and sub after the accepting edge SHALL NOT affect the result.
REQ-012 The counter SHALL be $clog2(WIDTH)+1 bits wide; it SHALL never wrap within an operation.
REQ-013 If in_valid and out_ready are both high in DONE, the block SHALL return to IDLE without accepting; acceptance occurs on a later edge.

Reset
REQ-014 While rst_n=0 at a clock edge, the block SHALL:
- set the FSM to IDLE;
- set in_ready=1 and out_valid=0, busy=0;
- set sum=0, cout=0, ovf=0;
- clear the counter and carry register.
REQ-015 A reset asserted in RUN or DONE SHALL abort the operation with no partial result visible; the first operation after reset SHALL be correct.

Structure
REQ-016 A shared package serial_adder_pkg SHALL hold the FSM state enum typedef (IDLE, RUN, DONE).
REQ-017 The bit slice SHALL be an instance of the existing full_adder sub-module (a, b, cin -> sum, cout); no other sub-modules.

Verification
REQ-018 With WIDTH=8, the bench SHALL cover these directed scenarios:
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; out_valid exactly 9 edges after accept.
- a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1.
- a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, cin=0, sub=1 -> sum=0x7F, ovf=1.
- out_ready held low 5 cycles in DONE -> sum, cout and ovf unchanged, in_ready=0; a, b changed mid-RUN -> result unchanged.
- rst_n pulsed low at bit 4 of RUN -> next edge IDLE, out_valid=0, sum=0; next operation 0x12+0x34 -> 0x46.
REQ-019 With WIDTH=4, the bench SHALL run an exhaustive sweep of all a, b, cin and sub combinations (1024), each compared against a behavioural model for sum, cout and ovf.
